issue_csr_fifo: RTL and testbench
=================================

Name: issue_csr_fifo

Overview:
- Show-ahead FIFO between the issue stage (producer) and execute_csr (consumer). Carries issue_execute_pack_t entries.
- Presents the head entry combinationally with a valid flag, so execute_csr samples and pops the head in the same cycle.
- Cleared in one cycle by the commit-stage flush.

Parameters:
- DEPTH, 4, number of entries; any integer >= 2; pointers wrap explicitly at DEPTH (no power-of-2 requirement).
- CNT_WIDTH, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- issue_csr_fifo_push  in  1  issue requests to write issue_csr_fifo_data_in.
- issue_csr_fifo_data_in  in  issue_execute_pack_t  entry to enqueue.
- issue_csr_fifo_full  out  1  count == DEPTH.
- issue_csr_fifo_count  out  CNT_WIDTH  current occupancy; issue uses it for free-slot accounting.
- issue_csr_fifo_data_out  out  issue_execute_pack_t  head entry.
- issue_csr_fifo_data_out_valid  out  1  count != 0.
- issue_csr_fifo_pop  in  1  execute_csr consumed the head this cycle.
- issue_csr_fifo_flush  in  1  commit_feedback_pack.enable && commit_feedback_pack.flush.

Behaviour:
- State: storage array mem[DEPTH], wptr, rptr (0..DEPTH-1), count (0..DEPTH). Storage is not reset.
- Reset (async assert, any time, including mid-push/pop):
  - wptr = rptr = count = 0.
  - full = 0, data_out_valid = 0, data_out = all-zero.
  - Outputs take these values immediately on assertion, not at the next edge.
- Accept rules, evaluated on registered state at the rising edge:
  - push_ok = push && !full. A full FIFO does not accept a push even when a pop occurs in the same cycle (no same-cycle slot reuse).
  - pop_ok = pop && (count != 0). No empty bypass: push+pop on an empty FIFO enqueues only, and pop is ignored.
- Edge update when flush = 0:
  - push_ok: mem[wptr] <= data_in; wptr <= (wptr == DEPTH-1) ? 0 : wptr+1.
  - pop_ok: rptr <= (rptr == DEPTH-1) ? 0 : rptr+1.
  - count <= count + push_ok - pop_ok. Simultaneous push_ok and pop_ok leaves count unchanged.
- Flush (highest priority below reset):
  - At the edge: wptr = rptr = count = 0.
  - Same-cycle push and pop are discarded.
  - Next cycle: data_out_valid = 0, full = 0.
- Outputs (combinational from registered state):
  - data_out = mem[rptr] when count != 0, else all-zero (so data_out.enable = 0 when empty).
  - data_out_valid = (count != 0); full = (count == DEPTH); count = count.
- Latency: an entry pushed at edge N is visible on data_out (if it is the head) after edge N, i.e. 1 cycle. A pop at edge N exposes the next entry after edge N.
- Overflow (push while full) and underflow (pop while empty) are dropped silently with no state change.
- Simulation-only checks: flag push while full and pop while empty.
- Ordering is strict FIFO across pointer wrap-around. Entry contents pass through bit-exact.

Test Plan:
- Reset: hold rst=1 with push=1 -> count=0, valid=0, full=0, data_out.enable=0. Deassert rst -> no entry present.
- Fill/drain, DEPTH=4:
  - Push rob_id 1,2,3,4 on consecutive cycles -> full=1, count=4 after the 4th edge.
  - Extra push (rob_id 5) is dropped.
  - Pop 4 times -> data_out.rob_id sequence 1,2,3,4, then valid=0.
- Wrap-around: push/pop streaming 10 entries (rob_id 0..9) with count held at 2 -> output order 0..9, count stays 2, pointers pass index 3->0 twice.
- Simultaneous events:
  - push+pop with count=2 -> count stays 2, head advances.
  - push+pop with count=0 -> count=1, the pushed entry is visible next cycle.
  - push+pop with count=4 -> push dropped, count=3.
- Flush: with 3 entries, flush=1 together with push=1 and pop=1 -> next cycle count=0, valid=0, full=0. A following push of rob_id 7 -> head rob_id 7, count=1.
- Async reset mid-stream: with count=3, assert rst between edges -> valid and full drop before the next edge. After release, a push of rob_id 2 appears as the only entry.

Source files
------------

// File: rtl/issue_csr_fifo.sv
// Show-ahead FIFO carrying issue_execute_pack_t entries from issue to execute_csr.
// Head entry is presented combinationally; commit flush clears it in one cycle.

package issue_csr_fifo_pkg;

  typedef struct packed {
    logic        enable;
    logic [5:0]  rob_id;
    logic [11:0] csr_addr;
    logic [2:0]  csr_op;
    logic [31:0] rs1_data;
    logic [4:0]  rd_addr;
  } issue_execute_pack_t;

endpackage

module issue_csr_fifo
  import issue_csr_fifo_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_csr_fifo_push,
  input  issue_execute_pack_t  issue_csr_fifo_data_in,
  output logic                 issue_csr_fifo_full,
  output logic [CNT_WIDTH-1:0] issue_csr_fifo_count,
  output issue_execute_pack_t  issue_csr_fifo_data_out,
  output logic                 issue_csr_fifo_data_out_valid,
  input  logic                 issue_csr_fifo_pop,
  input  logic                 issue_csr_fifo_flush
);

  localparam int                   PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  issue_execute_pack_t  mem [DEPTH];
  logic [PTR_W-1:0]     wptr;
  logic [PTR_W-1:0]     rptr;
  logic [CNT_WIDTH-1:0] count;
  logic                 full;
  logic                 not_empty;
  logic                 push_ok;
  logic                 pop_ok;

  assign full      = (count == FULL_CNT);
  assign not_empty = (count != '0);
  // A full FIFO refuses a push even if the head is popped in the same cycle.
  assign push_ok   = issue_csr_fifo_push && !full;
  assign pop_ok    = issue_csr_fifo_pop && not_empty;

  always_ff @(posedge clk) begin
    if (push_ok && !issue_csr_fifo_flush) begin
      mem[wptr] <= issue_csr_fifo_data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (issue_csr_fifo_flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_ok) begin
        wptr <= (wptr == LAST_PTR) ? '0 : wptr + 1'b1;
      end
      if (pop_ok) begin
        rptr <= (rptr == LAST_PTR) ? '0 : rptr + 1'b1;
      end
      if (push_ok && !pop_ok) begin
        count <= count + 1'b1;
      end else if (!push_ok && pop_ok) begin
        count <= count - 1'b1;
      end
    end
  end

  assign issue_csr_fifo_full           = full;
  assign issue_csr_fifo_count          = count;
  assign issue_csr_fifo_data_out_valid = not_empty;
  assign issue_csr_fifo_data_out       = not_empty ? mem[rptr] : '0;

  // Dropped overflow/underflow requests are legal but worth seeing in simulation.
  overflow_seen: cover property (@(posedge clk) disable iff (rst)
    issue_csr_fifo_push && full && !issue_csr_fifo_flush);
  underflow_seen: cover property (@(posedge clk) disable iff (rst)
    issue_csr_fifo_pop && !not_empty && !issue_csr_fifo_flush);

endmodule

// File: tb/tb_issue_csr_fifo.sv
// Scoreboard bench for issue_csr_fifo: stimulus queues expected entries, a monitor
// checks each popped head in order; status outputs are checked against hand values.

module tb_issue_csr_fifo;
  import issue_csr_fifo_pkg::*;

  localparam int DEPTH     = 4;
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);

  logic                 clk;
  logic                 rst;
  logic                 push;
  issue_execute_pack_t  data_in;
  logic                 full;
  logic [CNT_WIDTH-1:0] count;
  issue_execute_pack_t  data_out;
  logic                 valid;
  logic                 pop;
  logic                 flush;

  issue_execute_pack_t  exp_q[$];
  int                   model_count;
  int                   n_checks;
  int                   n_fail;

  issue_csr_fifo #(.DEPTH(DEPTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .issue_csr_fifo_push           (push),
    .issue_csr_fifo_data_in        (data_in),
    .issue_csr_fifo_full           (full),
    .issue_csr_fifo_count          (count),
    .issue_csr_fifo_data_out       (data_out),
    .issue_csr_fifo_data_out_valid (valid),
    .issue_csr_fifo_pop            (pop),
    .issue_csr_fifo_flush          (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic issue_execute_pack_t make_entry(input int rob);
    issue_execute_pack_t e;
    e.enable   = 1'b1;
    e.rob_id   = 6'(rob);
    e.csr_addr = 12'h300 + 12'(rob);
    e.csr_op   = 3'(rob);
    e.rs1_data = 32'hA5A5_0000 ^ (32'(rob) * 32'h0101_0101);
    e.rd_addr  = 5'(rob + 3);
    return e;
  endfunction

  task automatic checkValue(input string name, input int actual, input int required);
    n_checks++;
    if (actual != required) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  task automatic checkOutput(input string name, input int exp_count, input bit exp_valid,
                             input bit exp_full);
    checkValue({name, ".count"}, int'(count), exp_count);
    checkValue({name, ".valid"}, int'(valid), int'(exp_valid));
    checkValue({name, ".full"}, int'(full), int'(exp_full));
  endtask

  task automatic checkHead(input string name, input int exp_rob);
    issue_execute_pack_t e;
    e = make_entry(exp_rob);
    n_checks++;
    if (data_out !== e) begin
      n_fail++;
      $display("[TB] FAIL %s: head got %h, expected %h", name, data_out, e);
    end
  endtask

  // Inputs change at posedge+1; the scoreboard is updated with what the edge will accept.
  task automatic applyStimulus(input bit do_push, input bit do_pop, input bit do_flush,
                               input int rob);
    push    = do_push;
    pop     = do_pop;
    flush   = do_flush;
    data_in = make_entry(rob);
    if (do_flush) begin
      exp_q.delete();
      model_count = 0;
    end else begin
      if (do_push && model_count != DEPTH) begin
        exp_q.push_back(make_entry(rob));
        model_count++;
      end
      if (do_pop && model_count != 0 && !(do_push && model_count == 1 && exp_q.size() == 1
                                          && int'(count) == 0)) begin
        model_count--;
      end
    end
    @(posedge clk);
    #1;
    push  = 1'b0;
    pop   = 1'b0;
    flush = 1'b0;
  endtask

  // Monitor: the head handed to the consumer must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && pop && valid && !flush) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL monitor_pop: got rob_id %0d, expected no entry", data_out.rob_id);
      end else begin
        issue_execute_pack_t e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          n_fail++;
          $display("[TB] FAIL monitor_pop: got %h, expected %h", data_out, e);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    model_count = 0;
    rst         = 1'b1;
    push        = 1'b1;
    pop         = 1'b0;
    flush       = 1'b0;
    data_in     = make_entry(9);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_held", 0, 1'b0, 1'b0);
    checkValue("reset_held.enable", int'(data_out.enable), 0);
    rst  = 1'b0;
    push = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("after_reset", 0, 1'b0, 1'b0);

    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, i);
      checkOutput($sformatf("fill_%0d", i), i, 1'b1, i == 4);
    end
    checkHead("fill_head", 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 5);
    checkOutput("overflow_drop", 4, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 0);
      checkOutput($sformatf("drain_%0d", i), 4 - i, i != 4, 1'b0);
    end
    checkValue("drained.enable", int'(data_out.enable), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    checkOutput("underflow_drop", 0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    for (int i = 2; i <= 9; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, i);
      checkOutput($sformatf("stream_%0d", i), 2, 1'b1, 1'b0);
    end
    checkHead("stream_head", 8);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    checkOutput("stream_done", 0, 1'b0, 1'b0);

    applyStimulus(1'b1, 1'b0, 1'b0, 10);
    applyStimulus(1'b1, 1'b0, 1'b0, 11);
    applyStimulus(1'b1, 1'b1, 1'b0, 12);
    checkOutput("pushpop_cnt2", 2, 1'b1, 1'b0);
    checkHead("pushpop_cnt2_head", 11);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 13);
    checkOutput("pushpop_empty", 1, 1'b1, 1'b0);
    checkHead("pushpop_empty_head", 13);
    for (int i = 14; i <= 16; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, i);
    end
    checkOutput("refill", 4, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 17);
    checkOutput("pushpop_full", 3, 1'b1, 1'b0);
    checkHead("pushpop_full_head", 14);

    applyStimulus(1'b1, 1'b1, 1'b1, 18);
    checkOutput("flush", 0, 1'b0, 1'b0);
    checkValue("flush.enable", int'(data_out.enable), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 7);
    checkOutput("after_flush", 1, 1'b1, 1'b0);
    checkHead("after_flush_head", 7);

    applyStimulus(1'b1, 1'b0, 1'b0, 8);
    applyStimulus(1'b1, 1'b0, 1'b0, 9);
    checkOutput("pre_async", 3, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    model_count = 0;
    #1;
    checkOutput("async_reset", 0, 1'b0, 1'b0);
    checkValue("async_reset.enable", int'(data_out.enable), 0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    checkOutput("post_async", 1, 1'b1, 1'b0);
    checkHead("post_async_head", 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 0);
    checkOutput("final_drain", 0, 1'b0, 1'b0);

    checkValue("scoreboard_leftover", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
